// File: rtl/lbm_pkg.sv
// lbm_pkg: shared types and defaults for the LBM timestep scheduler
// Holds the scheduler FSM state enum, default lattice size and step-count width.
package lbm_pkg;
    localparam int GRID_W_DEF = 8;
    localparam int GRID_H_DEF = 8;
    localparam int STEP_W     = 16;
    typedef enum logic [2:0] {IDLE, COLLIDE, DRAIN, STREAM, STEP_END} state_t;
endpackage

// File: rtl/lbm_step_scheduler_cell_iter.sv
// lbm_cell_iter: row-major x/y raster counter over the lattice
// Ports: clk_in/rst_in clock and async reset, adv_in steps to the next cell
// (wrapping to (0,0) after the last), x_out/y_out current cell, last_out
// high while the current cell is (GRID_W-1,GRID_H-1).
module lbm_cell_iter #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int XW     = $clog2(GRID_W),
    parameter int YW     = $clog2(GRID_H)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          adv_in,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          last_out
);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_last, y_last;
    always_comb begin
        x_last = x_q == XMAX;
        y_last = y_q == YMAX;
        x_d = !adv_in ? x_q : x_last ? '0 : x_q + 1'b1;
        y_d = !(adv_in && x_last) ? y_q : y_last ? '0 : y_q + 1'b1;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
    assign x_out    = x_q;
    assign y_out    = y_q;
    assign last_out = x_last && y_last;
endmodule

// File: rtl/lbm_step_scheduler.sv
// lbm_step_scheduler: sequences collide / drain / stream passes for a batch of LBM timesteps
// Ports: clk_in, rst_in (async active-high); start_in + num_steps_in request a batch;
// col_valid_out/col_ready_in/col_x_out/col_y_out issue cells to the collision unit,
// col_retire_in reports completed write-backs; str_start_out/str_done_in run the
// streaming pass; busy_out, done_out, step_cnt_out, err_out (sticky) report status.
// Optional macro LBM_SCHED_PAUSE_EN adds pause_in, which stalls between timesteps.
module lbm_step_scheduler
    import lbm_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
`ifdef LBM_SCHED_PAUSE_EN
    input  logic                      pause_in,
`endif
    input  logic                      start_in,
    input  logic [STEP_W-1:0]         num_steps_in,
    output logic                      col_valid_out,
    input  logic                      col_ready_in,
    output logic [$clog2(GRID_W)-1:0] col_x_out,
    output logic [$clog2(GRID_H)-1:0] col_y_out,
    input  logic                      col_retire_in,
    output logic                      str_start_out,
    input  logic                      str_done_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [STEP_W-1:0]         step_cnt_out,
    output logic                      err_out
);
    localparam int OW = $clog2(GRID_W * GRID_H + 1);
    state_t            state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d, cnt_q, cnt_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              err_q, err_d, str_q;
    logic              acc, last, bad_ret, ret_ok, bad, hold;
`ifdef LBM_SCHED_PAUSE_EN
    assign hold = pause_in;
`else
    assign hold = 1'b0;
`endif
    lbm_cell_iter #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_iter (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .adv_in  (acc),
        .x_out   (col_x_out),
        .y_out   (col_y_out),
        .last_out(last)
    );
    assign col_valid_out = state_q == COLLIDE;
    assign acc           = col_valid_out && col_ready_in;
    // Illegal retires and stray stream-done pulses only raise the error flag.
    assign bad_ret = col_retire_in && (outst_q == '0 || state_q == STREAM || state_q == IDLE);
    assign ret_ok  = col_retire_in && !bad_ret;
    assign bad     = bad_ret || (str_done_in && state_q != STREAM);
    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        cnt_d   = cnt_q;
        outst_d = outst_q + OW'(acc) - OW'(ret_ok);
        err_d   = err_q || bad;
        case (state_q)
            IDLE: if (start_in) begin
                steps_d = num_steps_in;
                cnt_d   = '0;
                state_d = num_steps_in == '0 ? STEP_END : COLLIDE;
            end
            COLLIDE: if (acc && last) state_d = DRAIN;
            DRAIN: if (outst_q == '0) state_d = STREAM;
            STREAM: if (str_done_in) begin
                state_d = STEP_END;
                cnt_d   = cnt_q + 1'b1;
            end
            STEP_END: state_d = cnt_q == steps_q ? IDLE : hold ? STEP_END : COLLIDE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            steps_q <= '0;
            cnt_q   <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
            str_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            str_q   <= state_d == STREAM && state_q != STREAM;
        end
    end
    assign str_start_out = str_q;
    assign busy_out      = state_q != IDLE;
    assign done_out      = state_q == STEP_END && cnt_q == steps_q;
    assign step_cnt_out  = cnt_q;
    assign err_out       = err_q;
endmodule

// File: doc/lbm_step_scheduler.md
LBM_STEP_SCHEDULER -- requirements
Module: lbm_step_scheduler

Interface
REQ-001 Parameter GRID_W, default 8, lattice width in cells (>=2).
REQ-002 Parameter GRID_H, default 8, lattice height in cells (>=2).
REQ-003 clk_in  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 start_in  input  1  one-cycle request to run a batch of timesteps.
REQ-006 num_steps_in  input  16  number of timesteps; sampled when start_in is accepted.
REQ-007 col_valid_out  output  1  a cell address is offered to the collision unit.
REQ-008 col_ready_in  input  1  the collision unit accepts the offered cell.
REQ-009 col_x_out / col_y_out  output  clog2(GRID_W) / clog2(GRID_H)  cell coordinates.
REQ-010 col_retire_in  input  1  one-cycle pulse per cell whose collision write-back is complete.
REQ-011 str_start_out  output  1  one-cycle pulse that launches the streaming pass.
REQ-012 str_done_in  input  1  one-cycle pulse when the streaming pass finishes.
REQ-013 busy_out  output  1  high from batch acceptance until done_out.
REQ-014 done_out  output  1  one-cycle pulse at batch completion.
REQ-015 step_cnt_out  output  16  completed timesteps in the current or last batch.
REQ-016 err_out  output  1  sticky protocol-error flag.

Function
REQ-017 FSM states SHALL be IDLE, COLLIDE, DRAIN, STREAM, STEP_END.
REQ-018 IDLE: a start_in pulse SHALL be accepted, latch num_steps_in, clear step_cnt_out, and set busy_out on the next cycle. If the latched value is 0, the FSM SHALL go to STEP_END; otherwise it SHALL go to COLLIDE.
REQ-019 start_in SHALL be ignored whenever busy_out is 1.
REQ-020 COLLIDE SHALL issue every cell exactly once in row-major order: x increments fastest, starting at (0,0) and ending at (GRID_W-1,GRID_H-1). The address SHALL advance only on the cycle where col_valid_out and col_ready_in are both 1.
REQ-021 While col_valid_out is 1 and col_ready_in is 0, col_valid_out, col_x_out and col_y_out SHALL remain stable.
REQ-022 An outstanding counter SHALL track cells in flight: +1 on accept, -1 on col_retire_in. When both occur in the same cycle the count SHALL be unchanged.
REQ-023 After the last cell is accepted, the FSM SHALL enter DRAIN and col_valid_out SHALL be 0 from the next cycle.
REQ-024 DRAIN SHALL exit to STREAM in the cycle after the outstanding count reaches 0. STREAM entry SHALL assert str_start_out for exactly one cycle.
REQ-025 In STREAM, str_done_in SHALL move the FSM to STEP_END and increment step_cnt_out in the same edge.
REQ-026 STEP_END: if step_cnt_out equals the latched step count, the FSM SHALL pulse done_out, clear busy_out and return to IDLE. Otherwise it SHALL return to COLLIDE at cell (0,0).
REQ-027 err_out SHALL be set by any of: col_retire_in while the outstanding count is 0; str_done_in outside STREAM; col_retire_in in STREAM or IDLE. A flagged event SHALL not change any count.

Reset
REQ-028 On rst_in, the FSM SHALL enter IDLE, all counters and coordinates SHALL be 0, and every output SHALL be 0. This holds mid-batch, discarding in-flight work.

Configuration
REQ-029 With macro LBM_SCHED_PAUSE_EN defined, the block SHALL have input pause_in (1 bit). When pause_in is 1 in STEP_END and the batch is not finished, the FSM SHALL hold with busy_out=1 and resume COLLIDE on the first cycle pause_in is 0. Without the macro, the port SHALL be absent and STEP_END SHALL never stall.

Structure
REQ-030 Package lbm_pkg SHALL hold the FSM state enum, the default grid sizes and the step-count width.
REQ-031 A sub-module lbm_cell_iter (x/y raster counter with advance and last-cell flag) SHALL be instantiated once.

Verification
REQ-032 GRID 4x2, start with num_steps_in=1, col_ready_in held 1, each retire 3 cycles after accept → 8 addresses issued in order (0,0)..(3,1); one str_start_out; done_out; step_cnt_out=1.
REQ-033 num_steps_in=3 with random col_ready_in backpressure → addresses stable while stalled, 24 accepts total, 3 str_start_out pulses, step_cnt_out=3.
REQ-034 num_steps_in=0 → no col_valid_out or str_start_out; done_out pulses within 3 cycles of start.
REQ-035 rst_in asserted mid-DRAIN → all outputs 0 immediately; a following start runs a full batch cleanly.
REQ-036 Spurious str_done_in during COLLIDE → err_out=1 and remains 1; the batch still completes correctly.
REQ-037 With LBM_SCHED_PAUSE_EN, pause_in=1 held over the step boundary for 10 cycles → no col_valid_out during the pause; COLLIDE resumes one cycle after release.
